// File: rtl/fp8_mul_sequencer.sv
// Collects operand bytes A then B, issues them to the FP8 multiplier, and waits MUL_LATENCY cycles.
// It then holds the product on a valid/ready port; source is stalled (in_ready low) until the result is taken.
module fp8_mul_sequencer #(
  parameter int MUL_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] mul_a,
  output logic [7:0] mul_b,
  output logic       mul_start,
  input  logic [7:0] mul_result,
  output logic [7:0] res_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       busy,
  output logic [7:0] op_count
);

  typedef enum logic [2:0] {IDLE, GET_B, ISSUE, WAIT, HOLD} state_t;

  state_t     state;
  logic [3:0] cnt;

  // Handshake strobes depend only on registered state and ena, never on in_valid/res_ready.
  assign in_ready  = rst_n && ena && (state == IDLE || state == GET_B);
  assign mul_start = rst_n && ena && (state == ISSUE);
  assign res_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      mul_a    <= 8'd0;
      mul_b    <= 8'd0;
      res_data <= 8'd0;
      op_count <= 8'd0;
      cnt      <= 4'd0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mul_a <= in_data;
            state <= GET_B;
          end
        end
        GET_B: begin
          if (in_valid) begin
            mul_b <= in_data;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= 4'(MUL_LATENCY - 1);
          state <= WAIT;
        end
        WAIT: begin
          // cnt reaches zero in the cycle the multiplier output becomes valid.
          if (cnt == 4'd0) begin
            res_data <= mul_result;
            state    <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            op_count <= op_count + 8'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_mul_sequencer.sv
// Bench for fp8_mul_sequencer: three instances (latency 1, 3, 15) each with a gated multiplier stub;
// results are checked against a scoreboard queue filled when operands are sent.
module tb_fp8_mul_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n     [3];
  logic       ena       [3];
  logic [7:0] in_data   [3];
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [7:0] mul_a     [3];
  logic [7:0] mul_b     [3];
  logic       mul_start [3];
  logic [7:0] mul_result[3];
  logic [7:0] res_data  [3];
  logic       res_valid [3];
  logic       res_ready [3];
  logic       busy      [3];
  logic [7:0] op_count  [3];

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 15);
    logic [7:0] pipe [L];

    always @(posedge clk) begin
      if (ena[g]) begin
        pipe[0] <= 8'(mul_a[g][3:0]) * 8'(mul_b[g][3:0]);
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign mul_result[g] = pipe[L-1];

    fp8_mul_sequencer #(.MUL_LATENCY(L)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .ena       (ena[g]),
      .in_data   (in_data[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .mul_a     (mul_a[g]),
      .mul_b     (mul_b[g]),
      .mul_start (mul_start[g]),
      .mul_result(mul_result[g]),
      .res_data  (res_data[g]),
      .res_valid (res_valid[g]),
      .res_ready (res_ready[g]),
      .busy      (busy[g]),
      .op_count  (op_count[g])
    );
  end

  typedef struct {
    int         inst;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   start_cnt[3];
  int   start_cyc[3];
  int   rise_cyc [3];
  logic prev_rv  [3];

  function automatic logic [7:0] prod(input logic [7:0] a, input logic [7:0] b);
    return 8'(a[3:0]) * 8'(b[3:0]);
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 15);
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (mul_start[i]) begin
          start_cnt[i]++;
          start_cyc[i] = cyc;
        end
        if (res_valid[i] && !prev_rv[i]) rise_cyc[i] = cyc;
        prev_rv[i] = res_valid[i];
        if (rst_n[i] && ena[i] && res_valid[i] && res_ready[i]) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: inst %0d delivered %02h, nothing expected", i, res_data[i]);
          end else begin
            e = sb.pop_front();
            if (e.inst !== i || res_data[i] !== e.val) begin
              n_err++;
              $display("FAIL sb_result: inst %0d got %02h, expected inst %0d value %02h",
                       i, res_data[i], e.inst, e.val);
            end
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input int i, input logic [7:0] d, output int acc);
    int n;
    n = 0;
    acc = -1;
    in_data[i]  = d;
    in_valid[i] = 1'b1;
    @(negedge clk);
    while (!in_ready[i]) begin
      n++;
      if (n > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: inst %0d byte %02h never accepted", i, d);
        in_valid[i] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    tick();
    in_valid[i] = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_start(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (!mul_start[i]) begin
      n++;
      if (n > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL start_timeout: inst %0d no mul_start", i);
        return;
      end
      @(negedge clk);
    end
    tick();
  endtask

  task automatic wait_done(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (!(res_valid[i] && res_ready[i] && ena[i])) begin
      n++;
      if (n > 300) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_timeout: inst %0d result never handed over", i);
        return;
      end
      @(negedge clk);
    end
    tick();
  endtask

  task automatic do_op(input int i, input logic [7:0] a, input logic [7:0] b);
    int   acc;
    exp_t e;
    send_byte(i, a, acc);
    send_byte(i, b, acc);
    e.inst = i;
    e.val  = prod(a, b);
    sb.push_back(e);
    wait_done(i);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; ena[i] = 1'b1; in_valid[i] = 1'b0;
      in_data[i] = 8'h00; res_ready[i] = 1'b0;
      start_cnt[i] = 0; start_cyc[i] = 0; rise_cyc[i] = 0; prev_rv[i] = 1'b0;
    end
    repeat (3) tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({in_ready[i], res_valid[i], busy[i], mul_start[i], mul_a[i], mul_b[i],
           res_data[i], op_count[i]} !== 36'h0) begin
        n_err++;
        $display("FAIL reset_state: inst %0d rdy=%b rv=%b busy=%b st=%b a=%02h b=%02h r=%02h cnt=%02h, expected all zero",
                 i, in_ready[i], res_valid[i], busy[i], mul_start[i], mul_a[i], mul_b[i],
                 res_data[i], op_count[i]);
      end
    end
    tick();
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready[0] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_idle_ready: got %b, expected 1", in_ready[0]);
    end
    tick();
  endtask

  task automatic test_basic();
    int   acc;
    exp_t e;
    res_ready[0] = 1'b1;
    start_cnt[0] = 0;
    send_byte(0, 8'hFF, acc);
    send_byte(0, 8'hFF, acc);
    e.inst = 0; e.val = 8'hE1;
    sb.push_back(e);
    wait_done(0);
    n_cmp++;
    if (start_cnt[0] !== 1 || start_cyc[0] !== acc) begin
      n_err++;
      $display("FAIL basic_start: %0d pulses at cycle %0d, expected 1 pulse at cycle %0d",
               start_cnt[0], start_cyc[0], acc);
    end
    n_cmp++;
    if (rise_cyc[0] !== start_cyc[0] + 2) begin
      n_err++;
      $display("FAIL basic_res_timing: res_valid rose at %0d, expected %0d", rise_cyc[0], start_cyc[0] + 2);
    end
    @(negedge clk);
    n_cmp++;
    if (op_count[0] !== 8'd1 || busy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done: op_count=%0d busy=%b, expected 1 and 0", op_count[0], busy[0]);
    end
    tick();
  endtask

  task automatic test_latency();
    for (int i = 1; i < 3; i++) begin
      res_ready[i] = 1'b1;
      start_cnt[i] = 0;
      do_op(i, 8'h07, 8'h05);
      n_cmp++;
      if (start_cnt[i] !== 1 || rise_cyc[i] !== start_cyc[i] + lat_of(i) + 1) begin
        n_err++;
        $display("FAIL latency_L%0d: %0d pulses, res_valid rose %0d cycles after start, expected 1 pulse and %0d",
                 lat_of(i), start_cnt[i], rise_cyc[i] - start_cyc[i], lat_of(i) + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int   acc;
    int   n;
    exp_t e;
    res_ready[1] = 1'b0;
    send_byte(1, 8'h07, acc);
    send_byte(1, 8'h05, acc);
    e.inst = 1; e.val = 8'h23;
    sb.push_back(e);
    n = 0;
    @(negedge clk);
    while (!res_valid[1] && n < 100) begin
      n++;
      @(negedge clk);
    end
    tick();
    in_data[1] = 8'h11; in_valid[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({res_valid[1], res_data[1], in_ready[1], mul_a[1], op_count[1]} !== {1'b1, 8'h23, 1'b0, 8'h07, 8'd1}) begin
        n_err++;
        $display("FAIL bp_hold cyc%0d: rv=%b data=%02h rdy=%b a=%02h cnt=%0d, expected 1 23 0 07 1",
                 k, res_valid[1], res_data[1], in_ready[1], mul_a[1], op_count[1]);
      end
    end
    tick();
    res_ready[1] = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++;
    if (op_count[1] !== 8'd2 || in_ready[1] !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: op_count=%0d in_ready=%b, expected 2 and 1", op_count[1], in_ready[1]);
    end
    tick();
    in_valid[1] = 1'b0;
    n_cmp++;
    if (mul_a[1] !== 8'h11 || op_count[1] !== 8'd2) begin
      n_err++;
      $display("FAIL bp_next_a: mul_a=%02h op_count=%0d, expected 11 and 2", mul_a[1], op_count[1]);
    end
    send_byte(1, 8'h03, acc);
    e.inst = 1; e.val = prod(8'h11, 8'h03);
    sb.push_back(e);
    wait_done(1);
  endtask

  task automatic timed_op(input logic [7:0] a, input logic [7:0] b, input bit fr, output int dur);
    int   t0;
    int   acc;
    exp_t e;
    t0 = cyc;
    send_byte(1, a, acc);
    if (fr) begin
      ena[1] = 1'b0; in_data[1] = b; in_valid[1] = 1'b1;
      repeat (5) begin
        @(negedge clk);
        n_cmp++;
        if ({in_ready[1], mul_start[1], busy[1], mul_a[1]} !== {1'b0, 1'b0, 1'b1, a}) begin
          n_err++;
          $display("FAIL freeze_getb: rdy=%b start=%b busy=%b a=%02h, expected 0 0 1 %02h",
                   in_ready[1], mul_start[1], busy[1], mul_a[1], a);
        end
        tick();
      end
      ena[1] = 1'b1;
    end
    send_byte(1, b, acc);
    e.inst = 1; e.val = prod(a, b);
    sb.push_back(e);
    wait_start(1);
    if (fr) begin
      ena[1] = 1'b0;
      repeat (5) begin
        @(negedge clk);
        n_cmp++;
        if ({in_ready[1], mul_start[1], res_valid[1]} !== 3'b000) begin
          n_err++;
          $display("FAIL freeze_wait: rdy=%b start=%b rv=%b, expected 000", in_ready[1], mul_start[1], res_valid[1]);
        end
        tick();
      end
      ena[1] = 1'b1;
    end
    wait_done(1);
    dur = cyc - t0;
  endtask

  task automatic test_ena_freeze();
    int d0;
    int d1;
    res_ready[1] = 1'b1;
    timed_op(8'h07, 8'h05, 1'b0, d0);
    start_cnt[1] = 0;
    timed_op(8'h0B, 8'h0D, 1'b1, d1);
    n_cmp++;
    if (d1 !== d0 + 10 || start_cnt[1] !== 1) begin
      n_err++;
      $display("FAIL freeze_duration: %0d cycles with %0d starts, expected %0d cycles and 1 start",
               d1, start_cnt[1], d0 + 10);
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    res_ready[1] = 1'b1;
    send_byte(1, 8'h09, acc);
    send_byte(1, 8'h04, acc);
    wait_start(1);
    rst_n[1] = 1'b0;
    tick();
    n_cmp++;
    if ({res_valid[1], busy[1], mul_a[1], mul_b[1], op_count[1]} !== 26'h0) begin
      n_err++;
      $display("FAIL midreset_state: rv=%b busy=%b a=%02h b=%02h cnt=%0d, expected all zero",
               res_valid[1], busy[1], mul_a[1], mul_b[1], op_count[1]);
    end
    rst_n[1] = 1'b1;
    do_op(1, 8'h02, 8'h03);
    n_cmp++;
    if (op_count[1] !== 8'd1) begin
      n_err++;
      $display("FAIL midreset_count: op_count=%0d, expected 1", op_count[1]);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    res_ready[0] = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 256; k++) do_op(0, 8'($urandom), 8'($urandom));
    n_cmp++;
    if (op_count[0] !== 8'h00 || cyc - t0 !== 256 * 5) begin
      n_err++;
      $display("FAIL wrap_256: op_count=%02h after %0d cycles, expected 00 after %0d",
               op_count[0], cyc - t0, 256 * 5);
    end
    do_op(0, 8'h0C, 8'h0A);
    n_cmp++;
    if (op_count[0] !== 8'h01) begin
      n_err++;
      $display("FAIL wrap_257: op_count=%02h, expected 01", op_count[0]);
    end
  endtask

  initial begin
    test_reset();
    fork
      monitor();
    join_none
    test_basic();
    test_latency();
    test_backpressure();
    test_ena_freeze();
    test_reset_mid();
    test_back_to_back();
    repeat (3) tick();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d results outstanding, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
